// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that time-shares an external 4-bit ripple adder,
// feeding it one nibble per cycle (LSB first) and assembling the full-width result.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [3:0]       add_s,
    input  logic             add_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-5:0] sum_sh_q;
    logic             carry_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] b_eff_d;
    logic [WIDTH-1:0] sum_d;
    logic             last_d;

    // Subtraction is a + ~b + 1, so B is inverted once at capture time.
    always_comb begin
        b_eff_d = sub ? ~b : b;
        sum_d   = {add_s, sum_sh_q};
        last_d  = (cnt_q == CW'(NIBBLES - 1));
    end

    // The external adder only sees live operands while running; it is parked at zero otherwise.
    assign add_a    = (state_q == RUN) ? a_sh_q[3:0] : 4'h0;
    assign add_b    = (state_q == RUN) ? b_sh_q[3:0] : 4'h0;
    assign add_ci   = (state_q == RUN) ? carry_q     : 1'b0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b_eff_d;
                        carry_q <= sub ? 1'b1 : cin;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b_eff_d[WIDTH-1];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_sh_q <= sum_d[WIDTH-1:4];
                    carry_q  <= add_co;
                    a_sh_q   <= a_sh_q >> 4;
                    b_sh_q   <= b_sh_q >> 4;
                    cnt_q    <= cnt_q + CW'(1);
                    // Final pass: the top nibble arrives now, so the result MSB is add_s[3].
                    if (last_d) begin
                        sum_q   <= sum_d;
                        cout_q  <= add_co;
                        ovf_q   <= (a_msb_q == b_msb_q) && (add_s[3] != a_msb_q);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: transaction-level arithmetic model checked every
// cycle, plus directed cases with hand-computed results, abort-by-reset and randomized traffic.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rstN = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         cinIn = 1'b0;
    logic         subIn = 1'b0;
    logic [3:0]   addA;
    logic [3:0]   addB;
    logic         addCi;
    logic [3:0]   addS;
    logic         addCo;
    logic         busy;
    logic         done;
    logic [W-1:0] sumOut;
    logic         coutOut;
    logic         ovfOut;

    int assertCount = 0;
    int failCount   = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .start    (start),
        .a        (opA),
        .b        (opB),
        .cin      (cinIn),
        .sub      (subIn),
        .add_a    (addA),
        .add_b    (addB),
        .add_ci   (addCi),
        .add_s    (addS),
        .add_co   (addCo),
        .busy     (busy),
        .done     (done),
        .sum      (sumOut),
        .cout     (coutOut),
        .overflow (ovfOut)
    );

    // The external 4-bit ripple adder the sequencer drives.
    assign {addCo, addS} = {1'b0, addA} + {1'b0, addB} + {4'b0, addCi};

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a whole operation is one wide addition; per-pass carries come from partial sums.
    bit         mBusy = 0;
    bit         mDone = 0;
    int         mPass = 0;
    logic [W-1:0] mA = '0;
    logic [W-1:0] mB = '0;
    logic         mC = 1'b0;
    logic [W-1:0] mSum = '0;
    logic         mCout = 1'b0;
    logic         mOvf = 1'b0;

    function automatic logic expCi(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int p);
        longint unsigned mask;
        longint unsigned s;
        mask = (64'd1 << (4 * p)) - 1;
        s    = (longint'(x) & mask) + (longint'(y) & mask) + longint'(c);
        return s[4 * p];
    endfunction

    always @(posedge clk or negedge rstN) begin
        logic [W:0] full;
        if (!rstN) begin
            mBusy = 0; mDone = 0; mPass = 0;
            mSum = '0; mCout = 1'b0; mOvf = 1'b0;
        end else begin
            mDone = 0;
            if (mBusy) begin
                mPass++;
                if (mPass == NIB) begin
                    full  = {1'b0, mA} + {1'b0, mB} + {{W{1'b0}}, mC};
                    mSum  = full[W-1:0];
                    mCout = full[W];
                    mOvf  = (mA[W-1] == mB[W-1]) && (mSum[W-1] != mA[W-1]);
                    mBusy = 0;
                    mDone = 1;
                    mPass = 0;
                end
            end else if (start) begin
                mA    = opA;
                mB    = subIn ? ~opB : opB;
                mC    = subIn ? 1'b1 : cinIn;
                mBusy = 1;
                mPass = 0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", busy, mBusy);
        checkOutput("done", done, mDone);
        checkOutput("sum", sumOut, mSum);
        checkOutput("cout", coutOut, mCout);
        checkOutput("overflow", ovfOut, mOvf);
        checkOutput("add_a", addA, mBusy ? mA[4*mPass +: 4] : 4'h0);
        checkOutput("add_b", addB, mBusy ? mB[4*mPass +: 4] : 4'h0);
        checkOutput("add_ci", addCi, mBusy ? expCi(mA, mB, mC, mPass) : 1'b0);
    end

    task automatic applyStimulus(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic sb);
        @(posedge clk);
        #1;
        start = s; opA = x; opB = y; cinIn = c; subIn = sb;
    endtask

    task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic sb,
                         input logic [W-1:0] eSum, input logic eCout, input logic eOvf,
                         input logic [3:0] eCi, input bit chkCi);
        logic [3:0] ci;
        int lat;
        ci  = '0;
        lat = -1;
        applyStimulus(1'b1, x, y, c, sb);
        @(posedge clk);
        #1;
        start = 1'b0;
        ci[0] = addCi;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i < 4) ci[i] = addCi;
            if (done) begin
                lat = i;
                break;
            end
        end
        checkOutput("latency", lat, 4);
        checkOutput("op sum", sumOut, eSum);
        checkOutput("op cout", coutOut, eCout);
        checkOutput("op overflow", ovfOut, eOvf);
        if (chkCi) checkOutput("add_ci per pass", ci, eCi);
    endtask

    initial begin
        int lat;
        #1 rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset sum", sumOut, 0);
        checkOutput("reset cout", coutOut, 0);
        checkOutput("reset overflow", ovfOut, 0);
        checkOutput("reset add_a", addA, 0);
        checkOutput("reset add_b", addB, 0);
        checkOutput("reset add_ci", addCi, 0);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Carries into nibbles 0..3 are 0,1,1,1 (bit i = pass i).
        runOp(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 4'b1110, 1);
        runOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000, 0);
        runOp(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 4'b0000, 0);
        runOp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0000, 0);
        runOp(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 4'b0000, 0);
        runOp(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0000, 0);
        runOp(16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, 4'b0000, 0);

        // Start with new operands mid-run must be ignored; held through done it starts the next op.
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1; opA = 16'hAAAA; opB = 16'h5555;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        checkOutput("ignored-start latency", lat, 2);
        checkOutput("ignored-start sum", sumOut, 16'h3333);
        opA = 16'h4000; opB = 16'h4000;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin lat = i; break; end
        end
        checkOutput("back-to-back spacing", lat, 5);
        checkOutput("back-to-back sum", sumOut, 16'h8000);
        checkOutput("back-to-back overflow", ovfOut, 1);
        checkOutput("back-to-back cout", coutOut, 0);

        // Reset during a run aborts it with no completion.
        applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rstN = 1'b0;
        #1;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort sum", sumOut, 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("no done after abort", done, 0);
        end
        runOp(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b0000, 0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = W'($urandom);
            y = W'($urandom);
            case ($urandom_range(0, 5))
                0: x = 16'h7FFF;
                1: y = 16'h8000;
                2: y = 16'hFFFF;
                default: ;
            endcase
            applyStimulus(($urandom_range(0, 2) == 0), x, y, 1'($urandom), 1'($urandom));
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
